// File: rtl/zeroasic_dsp_pkg.sv
// Shared definitions for the z1010 MAE front-end blocks.
//   macc_state_e : stream sequencer states
//   MAE_*_W      : operand and accumulator widths of the hard block
//   mae_depth()  : pipeline depth (input regs + product reg + accumulate stage)
package zeroasic_dsp_pkg;

    localparam int unsigned MAE_A_W = 18;
    localparam int unsigned MAE_B_W = 18;
    localparam int unsigned MAE_P_W = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } macc_state_e;

    // Cycles from operand acceptance until the product sits in the accumulator.
    function automatic int unsigned mae_depth(input int unsigned in_reg, input int unsigned mult_reg);
        return in_reg + mult_reg + 1;
    endfunction

endpackage

// File: rtl/dsp_macc_stream_if.sv
// Operand stream in, dot-product result stream out.
//   s_valid/s_ready/s_a/s_b/s_last : operand beats, framed by s_last
//   m_valid/m_ready/m_acc/m_len/m_ovf/m_len_err : one result per frame
// master = operand producer / result consumer, slave = the MAC block.
interface dsp_macc_stream_if #(
    parameter int unsigned A_W   = 18,
    parameter int unsigned B_W   = 18,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned LEN_W = 11
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [A_W-1:0]   s_a;
    logic signed [B_W-1:0]   s_b;
    logic                    s_last;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [ACC_W-1:0] m_acc;
    logic [LEN_W-1:0]        m_len;
    logic                    m_ovf;
    logic                    m_len_err;

    modport master (
        output s_valid, s_a, s_b, s_last, m_ready,
        input  s_ready, m_valid, m_acc, m_len, m_ovf, m_len_err
    );

    modport slave (
        input  s_valid, s_a, s_b, s_last, m_ready,
        output s_ready, m_valid, m_acc, m_len, m_ovf, m_len_err
    );
endinterface

// File: rtl/dsp_macc_core.sv
// Multiply-accumulate datapath shaped to fold into one MAE in feedback mode.
//   clk, rst_n     : clock, async active-low reset
//   in_valid/first : beat valid, beat is the first of a frame (load instead of add)
//   a, b           : signed operands
//   acc            : accumulator register
//   acc_load_c     : accumulator is loading a first product this cycle
//   acc_ovf_c      : current add overflows in two's complement
module dsp_macc_core
    import zeroasic_dsp_pkg::*;
#(
    parameter int unsigned A_W      = MAE_A_W,
    parameter int unsigned B_W      = MAE_B_W,
    parameter int unsigned ACC_W    = MAE_P_W,
    parameter int unsigned IN_REG   = 1,
    parameter int unsigned MULT_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_load_c,
    output logic                    acc_ovf_c
);

    localparam int unsigned PROD_W = A_W + B_W;

    logic signed [A_W-1:0]    a_s1;
    logic signed [B_W-1:0]    b_s1;
    logic                     v_s1;
    logic                     f_s1;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_s2;
    logic                     v_s2;
    logic                     f_s2;
    logic signed [ACC_W-1:0]  prod_ext_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic                     acc_add_c;

    // Optional operand registers (MAE A_REG/B_REG); valid/first ride alongside.
    generate
        if (IN_REG != 0) begin : g_in_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_s1 <= '0;
                    b_s1 <= '0;
                    v_s1 <= 1'b0;
                    f_s1 <= 1'b0;
                end else begin
                    a_s1 <= a;
                    b_s1 <= b;
                    v_s1 <= in_valid;
                    f_s1 <= in_first;
                end
            end
        end else begin : g_in_bypass
            always_comb begin
                a_s1 = a;
                b_s1 = b;
                v_s1 = in_valid;
                f_s1 = in_first;
            end
        end
    endgenerate

    assign prod_c = PROD_W'(a_s1) * PROD_W'(b_s1);

    // Optional product register (MAE MULT_HAS_REG).
    generate
        if (MULT_REG != 0) begin : g_mult_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_s2 <= '0;
                    v_s2    <= 1'b0;
                    f_s2    <= 1'b0;
                end else begin
                    prod_s2 <= prod_c;
                    v_s2    <= v_s1;
                    f_s2    <= f_s1;
                end
            end
        end else begin : g_mult_bypass
            always_comb begin
                prod_s2 = prod_c;
                v_s2    = v_s1;
                f_s2    = f_s1;
            end
        end
    endgenerate

    assign prod_ext_c = ACC_W'(prod_s2);
    assign sum_c      = acc + prod_ext_c;
    assign acc_load_c = v_s2 & f_s2;
    assign acc_add_c  = v_s2 & ~f_s2;
    // Same-sign operands whose sum flips sign.
    assign acc_ovf_c  = acc_add_c
                      & (acc[ACC_W-1] == prod_ext_c[ACC_W-1])
                      & (sum_c[ACC_W-1] != acc[ACC_W-1]);

    // Feedback accumulator: first beat loads, so frames need no clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_load_c) begin
            acc <= prod_ext_c;
        end else if (acc_add_c) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/dsp_macc_stream.sv
// Stream front-end for the z1010 MAE: sums a*b over each s_last-framed operand
// frame and returns one result per frame.
//   clk, resetn : clock, async active-low reset
//   bus         : dsp_macc_stream_if.slave (operand stream in, result stream out)
// Frames close on s_last or when the beat count reaches MAX_LEN.
module dsp_macc_stream
    import zeroasic_dsp_pkg::*;
#(
    parameter int unsigned A_W      = MAE_A_W,
    parameter int unsigned B_W      = MAE_B_W,
    parameter int unsigned ACC_W    = MAE_P_W,
    parameter int unsigned IN_REG   = 1,
    parameter int unsigned MULT_REG = 1,
    parameter int unsigned MAX_LEN  = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    dsp_macc_stream_if.slave   bus
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned DEPTH   = mae_depth(IN_REG, MULT_REG);
    localparam int unsigned DRAIN_W = 2;

    macc_state_e             state_q;
    logic                    s_ready_q;
    logic                    m_valid_q;
    logic signed [ACC_W-1:0] m_acc_q;
    logic [LEN_W-1:0]        m_len_q;
    logic                    m_ovf_q;
    logic                    m_len_err_q;
    logic [LEN_W-1:0]        beat_cnt_q;
    logic [DRAIN_W-1:0]      drain_cnt_q;
    logic                    ovf_q;
    logic                    len_err_q;

    logic                    fire_c;
    logic                    first_c;
    logic [LEN_W-1:0]        beat_nxt_c;
    logic                    at_max_c;
    logic signed [ACC_W-1:0] core_acc;
    logic                    core_load_c;
    logic                    core_ovf_c;

    assign fire_c     = bus.s_valid & s_ready_q;
    assign first_c    = (state_q == IDLE);
    assign beat_nxt_c = first_c ? LEN_W'(1) : beat_cnt_q + LEN_W'(1);
    assign at_max_c   = (beat_nxt_c == LEN_W'(MAX_LEN));

    dsp_macc_core #(
        .A_W      (A_W),
        .B_W      (B_W),
        .ACC_W    (ACC_W),
        .IN_REG   (IN_REG),
        .MULT_REG (MULT_REG)
    ) u_core (
        .clk        (clk),
        .rst_n      (resetn),
        .in_valid   (fire_c),
        .in_first   (first_c),
        .a          (bus.s_a),
        .b          (bus.s_b),
        .acc        (core_acc),
        .acc_load_c (core_load_c),
        .acc_ovf_c  (core_ovf_c)
    );

    // Frame sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_acc_q     <= '0;
            m_len_q     <= '0;
            m_ovf_q     <= 1'b0;
            m_len_err_q <= 1'b0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    s_ready_q <= 1'b1;
                    if (fire_c) begin
                        beat_cnt_q <= beat_nxt_c;
                        if (bus.s_last || at_max_c) begin
                            state_q     <= DRAIN;
                            s_ready_q   <= 1'b0;
                            drain_cnt_q <= '0;
                            len_err_q   <= ~bus.s_last;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                // Wait until the closing beat has reached the accumulator.
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                    if (drain_cnt_q == DRAIN_W'(DEPTH - 1)) begin
                        state_q     <= OUT;
                        m_valid_q   <= 1'b1;
                        m_acc_q     <= core_acc;
                        m_len_q     <= beat_cnt_q;
                        m_ovf_q     <= ovf_q;
                        m_len_err_q <= len_err_q;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Sticky overflow, restarted by the load of each frame's first product.
            if (core_load_c) begin
                ovf_q <= 1'b0;
            end else if (core_ovf_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_acc     = m_acc_q;
    assign bus.m_len     = m_len_q;
    assign bus.m_ovf     = m_ovf_q;
    assign bus.m_len_err = m_len_err_q;

endmodule

// File: tb/tb_dsp_macc_stream.sv
// Scoreboard bench for dsp_macc_stream. Three instances share the operand
// drive: defaults, ACC_W=38 (overflow) and MAX_LEN=4 (length limit); `sel`
// picks which instance's handshake and result the bench follows.
module tb_dsp_macc_stream;

    localparam int EXP_LAT = 4;

    typedef struct {
        longint acc;
        int     len;
        bit     ovf;
        bit     len_err;
        int     acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic signed [17:0] s_a = '0;
    logic signed [17:0] s_b = '0;

    int sel = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    exp_t   exp_q[$];
    exp_t   mon_e;
    bit     prev_valid = 1'b0;
    int     rise_cyc = 0;

    longint mdl_acc = 0;
    int     mdl_cnt = 0;
    bit     mdl_ovf = 1'b0;

    logic         sel_s_ready;
    logic         sel_m_valid;
    longint       sel_m_acc;
    int           sel_m_len;
    logic         sel_m_ovf;
    logic         sel_m_len_err;

    dsp_macc_stream_if #(.A_W(18), .B_W(18), .ACC_W(40), .LEN_W(11)) if_dflt ();
    dsp_macc_stream_if #(.A_W(18), .B_W(18), .ACC_W(38), .LEN_W(11)) if_ovf ();
    dsp_macc_stream_if #(.A_W(18), .B_W(18), .ACC_W(40), .LEN_W(3))  if_len ();

    assign if_dflt.s_valid = s_valid;
    assign if_dflt.s_a     = s_a;
    assign if_dflt.s_b     = s_b;
    assign if_dflt.s_last  = s_last;
    assign if_dflt.m_ready = m_ready;
    assign if_ovf.s_valid  = s_valid;
    assign if_ovf.s_a      = s_a;
    assign if_ovf.s_b      = s_b;
    assign if_ovf.s_last   = s_last;
    assign if_ovf.m_ready  = m_ready;
    assign if_len.s_valid  = s_valid;
    assign if_len.s_a      = s_a;
    assign if_len.s_b      = s_b;
    assign if_len.s_last   = s_last;
    assign if_len.m_ready  = m_ready;

    dsp_macc_stream u_dflt (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if_dflt.slave)
    );

    dsp_macc_stream #(.ACC_W(38)) u_ovf (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if_ovf.slave)
    );

    dsp_macc_stream #(.MAX_LEN(4)) u_len (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if_len.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (sel)
            1: begin
                sel_s_ready   = if_ovf.s_ready;
                sel_m_valid   = if_ovf.m_valid;
                sel_m_acc     = 64'(if_ovf.m_acc);
                sel_m_len     = 32'(if_ovf.m_len);
                sel_m_ovf     = if_ovf.m_ovf;
                sel_m_len_err = if_ovf.m_len_err;
            end
            2: begin
                sel_s_ready   = if_len.s_ready;
                sel_m_valid   = if_len.m_valid;
                sel_m_acc     = 64'(if_len.m_acc);
                sel_m_len     = 32'(if_len.m_len);
                sel_m_ovf     = if_len.m_ovf;
                sel_m_len_err = if_len.m_len_err;
            end
            default: begin
                sel_s_ready   = if_dflt.s_ready;
                sel_m_valid   = if_dflt.m_valid;
                sel_m_acc     = 64'(if_dflt.m_acc);
                sel_m_len     = 32'(if_dflt.m_len);
                sel_m_ovf     = if_dflt.m_ovf;
                sel_m_len_err = if_dflt.m_len_err;
            end
        endcase
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Two's-complement wrap of x to w bits, sign-extended back to 64.
    function automatic longint wrap(input longint x, input int w);
        longint r;
        r = x <<< (64 - w);
        return r >>> (64 - w);
    endfunction

    // Reference model: one accepted beat; pushes the expected result on frame close.
    task automatic model_beat(input logic signed [17:0] a, input logic signed [17:0] b,
                              input bit last, input int acc_cyc);
        int     w;
        int     max_len;
        longint p;
        longint s;
        exp_t   e;
        w       = (sel == 1) ? 38 : 40;
        max_len = (sel == 2) ? 4 : 1024;
        p = wrap(longint'(a) * longint'(b), w);
        if (mdl_cnt == 0) begin
            mdl_acc = p;
            mdl_ovf = 1'b0;
        end else begin
            s = wrap(mdl_acc + p, w);
            if (((mdl_acc < 0) == (p < 0)) && ((s < 0) != (mdl_acc < 0))) mdl_ovf = 1'b1;
            mdl_acc = s;
        end
        mdl_cnt++;
        if (last || mdl_cnt == max_len) begin
            e.acc     = mdl_acc;
            e.len     = mdl_cnt;
            e.ovf     = mdl_ovf;
            e.len_err = !last;
            e.acc_cyc = acc_cyc;
            exp_q.push_back(e);
            mdl_cnt = 0;
        end
    endtask

    // Drive one beat after `gap` idle cycles; returns #1 after the accepting edge.
    task automatic send(input logic signed [17:0] a, input logic signed [17:0] b,
                        input bit last, input int gap);
        int n;
        int acc_cyc;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = last;
        n = 0;
        @(negedge clk);
        while (!sel_s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sel_s_ready) begin
            check("s_ready_wait", 0, 1);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            model_beat(a, b, last, acc_cyc);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!sel_m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("m_valid_wait", 64'(sel_m_valid), 1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("result_count", exp_q.size(), 0);
    endtask

    task automatic do_reset(input int new_sel);
        #2;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        sel     = new_sel;
        mdl_cnt = 0;
        #2;
        check("rst_s_ready", 64'(sel_s_ready), 0);
        check("rst_m_valid", 64'(sel_m_valid), 0);
        check("rst_m_acc", sel_m_acc, 0);
        check("rst_m_len", sel_m_len, 0);
        check("rst_m_ovf", 64'(sel_m_ovf), 0);
        check("rst_m_len_err", 64'(sel_m_len_err), 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare on every result handshake of the followed instance.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_valid <= 1'b0;
        end else begin
            if (sel_m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("m_acc", sel_m_acc, mon_e.acc);
                    check("m_len", sel_m_len, mon_e.len);
                    check("m_ovf", 64'(sel_m_ovf), 64'(mon_e.ovf));
                    check("m_len_err", 64'(sel_m_len_err), 64'(mon_e.len_err));
                    check("latency", (prev_valid ? rise_cyc : cyc) - mon_e.acc_cyc, EXP_LAT);
                end
            end
            if (sel_m_valid && !prev_valid) rise_cyc <= cyc;
            prev_valid <= sel_m_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [17:0] ra;
        logic signed [17:0] rb;

        do_reset(0);

        // Three-beat frame, result held while m_ready is low.
        m_ready = 1'b0;
        send(18'sd3, 18'sd4, 1'b0, 0);
        send(-18'sd5, 18'sd6, 1'b0, 0);
        send(18'sd7, -18'sd8, 1'b1, 0);
        @(negedge clk);
        check("s_ready_drop", 64'(sel_s_ready), 0);
        wait_valid();
        repeat (3) @(negedge clk);
        check("out_hold_valid", 64'(sel_m_valid), 1);
        check("out_hold_s_ready", 64'(sel_s_ready), 0);
        check("out_hold_acc", sel_m_acc, -74);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_empty();

        // Single-beat frame of two most-negative operands.
        send(-18'sd131072, -18'sd131072, 1'b1, 0);
        wait_empty();

        // Back-to-back frames, m_ready held high.
        send(18'sd1, 18'sd1, 1'b0, 0);
        send(18'sd1, 18'sd1, 1'b1, 0);
        send(18'sd2, 18'sd2, 1'b0, 0);
        send(18'sd2, 18'sd2, 1'b1, 0);
        wait_empty();

        // Random operands with bubbles between beats.
        for (int i = 0; i < 6; i++) begin
            ra = 18'($urandom);
            rb = 18'($urandom);
            send(ra, rb, i == 5, int'($urandom_range(0, 3)));
        end
        wait_empty();

        // Reset mid-frame, then a fresh frame.
        send(18'sd9, 18'sd9, 1'b0, 0);
        send(18'sd9, 18'sd9, 1'b0, 0);
        do_reset(0);
        send(18'sd2, 18'sd3, 1'b1, 0);
        wait_empty();

        // Overflow on the 38-bit accumulator.
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            send(18'sd131071, 18'sd131071, i == 16, 0);
        end
        wait_empty();

        // MAX_LEN=4 closes the first frame, s_last closes the second.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            send(18'sd1, 18'sd1, i == 5, 0);
        end
        wait_empty();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
